i2c_slave_rx: RTL and testbench
===============================

// Module: i2c_slave_rx
// PURPOSE
//  I2C slave receive front-end sitting directly upstream of control_unit.
//  - Synchronises and deglitches the raw SCL/SDA bus lines.
//  - Detects START/STOP conditions and deserialises bytes MSB first.
//  - Presents bytes as byte_out/valid_out/start_out/stop_out.
//  - Drives the 9th-bit ACK on SDA when control_unit requests it via ack_in.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop stages in each SCL/SDA synchroniser (>=2)
//  DEGLITCH     2  consecutive equal synchronised samples before a level is accepted (>=1)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  scl_in      in   1  raw I2C SCL, asynchronous to clk
//  sda_in      in   1  raw I2C SDA, asynchronous to clk
//  ack_in      in   1  ACK request for the current byte (driven by control_unit ack_out)
//  sda_oe_out  out  1  1 = pull SDA low (open-drain enable), 0 = release
//  byte_out    out  8  last received byte, held until the next byte completes
//  valid_out   out  1  one-clk pulse: byte_out newly valid
//  start_out   out  1  one-clk pulse: START or repeated START detected
//  stop_out    out  1  one-clk pulse: STOP detected
// BEHAVIOUR
//  Reset
//  - All outputs 0. FSM in IDLE, bit counter 0.
//  - Filtered scl_s/sda_s reset to 1 (idle bus), so reset release never creates a false START.
//  Input conditioning
//  - scl_s/sda_s update only after DEGLITCH equal samples out of the synchroniser.
//  - Raw-to-filtered latency: SYNC_STAGES+DEGLITCH clk cycles.
//  - Edges are derived from the previous vs current value of scl_s/sda_s.
//  Bus conditions (evaluated every clk, highest priority, any state)
//  - START: sda_s 1->0 while scl_s==1. Action: start_out=1 next clk, bit counter=0,
//    sda_oe_out=0, state RX_BITS. A repeated START is handled identically.
//  - STOP: sda_s 0->1 while scl_s==1. Action: stop_out=1 next clk, sda_oe_out=0,
//    state IDLE. A partial byte is discarded (no valid_out).
//  - START and STOP on the same clk is impossible: they require opposite SDA edges.
//  FSM
//  - IDLE: ignore SCL/SDA activity except START.
//  - RX_BITS: on each scl_s rise, shift sda_s into an 8-bit shift register (MSB first)
//    and increment the counter.
//    - On the 8th rise: byte_out <= shift value; valid_out pulses the next clk;
//      state ACK_WAIT.
//  - ACK_WAIT: on the next scl_s fall, sample ack_in.
//    - ack_in==1: sda_oe_out=1 from the following clk, state ACK_DRIVE.
//    - ack_in==0: SDA stays released (NACK), state ACK_DRIVE.
//    - control_unit must settle ack_in between valid_out and that SCL fall.
//  - ACK_DRIVE: hold sda_oe_out through the 9th SCL high phase.
//    - On the next scl_s fall: sda_oe_out=0, counter=0, state RX_BITS.
//  - SDA is only driven or released while SCL is low, so own ACK edges never
//    decode as START/STOP.
//  Other
//  - Outputs are registered; all pulses last exactly one clk.
//  - valid_out is never asserted in the same clk as start_out or stop_out.
//  - Reset mid-byte or mid-ACK: SDA released immediately (async), FSM to IDLE;
//    a START is required before reception resumes.
// TESTING
//  - Reset: rst_n=0 with scl_in=sda_in=1, release -> all outputs 0;
//    no start_out for 20 clk.
//  - START + byte 0xA5 + ack_in=1 -> start_out pulse; valid_out pulse with byte_out=8'hA5;
//    sda_oe_out=1 exactly during the 9th SCL high; released at 9th fall.
//  - Bytes 0x3C then 0xFF, ack_in=0 on the second -> two valid_out pulses with
//    byte_out=8'h3C then 8'hFF; sda_oe_out stays 0 during the second ACK slot.
//  - START, 4 bits, repeated START, byte 0x81, STOP -> two start_out pulses;
//    one valid_out pulse with byte_out=8'h81; one stop_out pulse; FSM ends in IDLE.
//  - 1-clk glitches on SCL with DEGLITCH=2 during byte 0x5A -> byte_out=8'h5A;
//    no extra bits shifted.
//  - rst_n pulsed low while sda_oe_out=1 -> sda_oe_out=0 asynchronously;
//    bytes sent without a preceding START produce no valid_out.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// I2C slave receive front-end.
// Conditions raw SCL/SDA (synchroniser + deglitch filter), detects START/STOP,
// deserialises bytes MSB first and drives the 9th-bit ACK when requested.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   scl_in       raw SCL (asynchronous)
//   sda_in       raw SDA (asynchronous)
//   ack_in       ACK request for the current byte
//   sda_oe_out   1 = pull SDA low
//   byte_out     last received byte, held until the next byte completes
//   valid_out    one-clk pulse, byte_out newly valid
//   start_out    one-clk pulse, START / repeated START
//   stop_out     one-clk pulse, STOP
module i2c_slave_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEGLITCH    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       ack_in,
    output logic       sda_oe_out,
    output logic [7:0] byte_out,
    output logic       valid_out,
    output logic       start_out,
    output logic       stop_out
);

    localparam int unsigned CNT_W = $clog2(DEGLITCH + 1);
    localparam int unsigned BIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RX_BITS,
        ACK_WAIT,
        ACK_DRIVE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [CNT_W-1:0]       scl_cnt, sda_cnt;
    logic                   scl_s, sda_s, scl_prev, sda_prev;
    logic                   scl_sync_c, sda_sync_c;

    state_t           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_d;
    logic             valid_d, start_d, stop_d, oe_d;

    logic scl_rise_c, scl_fall_c, start_c, stop_c;

    assign scl_sync_c = scl_sync[SYNC_STAGES-1];
    assign sda_sync_c = sda_sync[SYNC_STAGES-1];

    // Synchronisers; reset to the idle (high) bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    // Deglitch: a new level is accepted after DEGLITCH consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s   <= 1'b1;
            scl_cnt <= '0;
        end else if (scl_sync_c == scl_s) begin
            scl_cnt <= '0;
        end else if (scl_cnt == CNT_W'(DEGLITCH - 1)) begin
            scl_s   <= scl_sync_c;
            scl_cnt <= '0;
        end else begin
            scl_cnt <= scl_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_s   <= 1'b1;
            sda_cnt <= '0;
        end else if (sda_sync_c == sda_s) begin
            sda_cnt <= '0;
        end else if (sda_cnt == CNT_W'(DEGLITCH - 1)) begin
            sda_s   <= sda_sync_c;
            sda_cnt <= '0;
        end else begin
            sda_cnt <= sda_cnt + CNT_W'(1);
        end
    end

    // Previous filtered levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_rise_c = ~scl_prev & scl_s;
    assign scl_fall_c = scl_prev & ~scl_s;
    assign start_c    = sda_prev & ~sda_s & scl_s;
    assign stop_c     = ~sda_prev & sda_s & scl_s;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_out   <= '0;
            valid_out  <= 1'b0;
            start_out  <= 1'b0;
            stop_out   <= 1'b0;
            sda_oe_out <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_out   <= byte_d;
            valid_out  <= valid_d;
            start_out  <= start_d;
            stop_out   <= stop_d;
            sda_oe_out <= oe_d;
        end
    end

    // Next state; bus conditions override whatever the FSM is doing
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_d    = byte_out;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        oe_d      = sda_oe_out;

        if (start_c) begin
            start_d   = 1'b1;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            state_d   = RX_BITS;
        end else if (stop_c) begin
            stop_d  = 1'b1;
            oe_d    = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                end
                RX_BITS: begin
                    if (scl_rise_c) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(7)) begin
                            byte_d  = shift_d;
                            valid_d = 1'b1;
                            state_d = ACK_WAIT;
                        end
                    end
                end
                ACK_WAIT: begin
                    // SCL just went low after bit 8: safe to start driving
                    if (scl_fall_c) begin
                        oe_d    = ack_in;
                        state_d = ACK_DRIVE;
                    end
                end
                ACK_DRIVE: begin
                    if (scl_fall_c) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = RX_BITS;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: an I2C master drives bytes; an event-queue model of
// expected START/STOP/byte events and ACK levels is checked every clock.
module tb_i2c_slave_rx;

    localparam int Q       = 8;
    localparam int K_START = 0;
    localparam int K_STOP  = 1;
    localparam int K_VALID = 2;

    typedef struct {
        int         kind;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n, scl_in, sda_m, ack_in;
    logic       sda_in;
    logic       sda_oe_out, valid_out, start_out, stop_out;
    logic [7:0] byte_out;

    always #5 clk = ~clk;

    // Open-drain bus: either side may pull SDA low
    assign sda_in = sda_m & ~sda_oe_out;

    i2c_slave_rx #(.SYNC_STAGES(2), .DEGLITCH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .ack_in     (ack_in),
        .sda_oe_out (sda_oe_out),
        .byte_out   (byte_out),
        .valid_out  (valid_out),
        .start_out  (start_out),
        .stop_out   (stop_out)
    );

    int n_chk = 0, n_pass = 0;
    int n_valid = 0, n_start = 0, n_stop = 0;
    int v0, s0, p0;
    ev_t evq[$];
    logic       hi_stable = 1'b0;
    logic       exp_oe = 1'b0;
    logic [7:0] model_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        if (evq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d want none at %0t", kind, $time);
        end else begin
            e = evq.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == K_VALID) begin
                chk("byte_out", 32'(byte_out), 32'(e.b));
                model_byte = e.b;
            end
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        if (!rst_n) begin
            model_byte = 8'h00;
        end else begin
            if (start_out) begin n_start++; expect_ev(K_START); end
            if (stop_out)  begin n_stop++;  expect_ev(K_STOP);  end
            if (valid_out) begin
                n_valid++;
                chk("valid_exclusive", 32'(start_out | stop_out), 32'd0);
                expect_ev(K_VALID);
            end else begin
                chk("byte_hold", 32'(byte_out), 32'(model_byte));
            end
            if (hi_stable) chk("sda_oe_scl_high", 32'(sda_oe_out), 32'(exp_oe));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL clock with SDA = b; optional 1-clk SCL glitches in both phases
    task automatic send_bit(input logic b, input logic glitch, input logic oe_hi);
        sda_m = b;
        if (glitch) begin
            tick(3); scl_in = 1'b1; tick(1); scl_in = 1'b0; tick(Q - 4);
        end else begin
            tick(Q);
        end
        scl_in = 1'b1;
        tick(6);
        exp_oe    = oe_hi;
        hi_stable = 1'b1;
        if (glitch) begin
            tick(3); scl_in = 1'b0; tick(1); scl_in = 1'b1; tick(4);
        end else begin
            tick(8);
        end
        hi_stable = 1'b0;
        tick(2);
        scl_in = 1'b0;
        tick(Q);
    endtask

    task automatic send_start();
        sda_m = 1'b1;
        tick(Q);
        scl_in = 1'b1;
        tick(8);
        sda_m = 1'b0;
        evq.push_back('{K_START, 8'h00});
        tick(8);
        scl_in = 1'b0;
        tick(Q);
    endtask

    task automatic send_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_in = 1'b1;
        tick(8);
        sda_m = 1'b1;
        evq.push_back('{K_STOP, 8'h00});
        tick(8);
    endtask

    // 8 data bits plus the ACK slot; in_frame says whether the slave should react
    task automatic send_byte(input logic [7:0] b, input logic ack, input logic in_frame,
                             input logic glitch);
        ack_in = ack;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && in_frame) evq.push_back('{K_VALID, b});
            send_bit(b[i], glitch, 1'b0);
        end
        send_bit(1'b1, 1'b0, ack & in_frame);
    endtask

    task automatic snap();
        v0 = n_valid; s0 = n_start; p0 = n_stop;
    endtask

    initial begin
        rst_n = 1'b0; scl_in = 1'b1; sda_m = 1'b1; ack_in = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(2);
        chk("rst_sda_oe", 32'(sda_oe_out), 32'd0);
        chk("rst_byte",   32'(byte_out),   32'd0);
        chk("rst_valid",  32'(valid_out),  32'd0);
        chk("rst_start",  32'(start_out),  32'd0);
        chk("rst_stop",   32'(stop_out),   32'd0);
        tick(20);
        chk("rst_no_start", 32'(n_start), 32'd0);

        // START + 0xA5 with ACK, STOP
        snap();
        send_start();
        send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("a5_oe_released", 32'(sda_oe_out), 32'd0);
        send_stop();
        tick(4);
        chk("a5_byte",  32'(byte_out), 32'h0000_00A5);
        chk("a5_valid", 32'(n_valid - v0), 32'd1);
        chk("a5_start", 32'(n_start - s0), 32'd1);
        chk("a5_stop",  32'(n_stop - p0), 32'd1);
        chk("a5_evq", 32'(evq.size()), 32'd0);

        // 0x3C ACK then 0xFF NACK
        snap();
        send_start();
        send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
        chk("3c_byte", 32'(byte_out), 32'h0000_003C);
        send_byte(8'hFF, 1'b0, 1'b1, 1'b0);
        chk("ff_byte", 32'(byte_out), 32'h0000_00FF);
        send_stop();
        tick(4);
        chk("3c_ff_valid", 32'(n_valid - v0), 32'd2);
        chk("3c_ff_evq", 32'(evq.size()), 32'd0);

        // START, 4 bits, repeated START, 0x81, STOP, then a byte with no START
        snap();
        send_start();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_start();
        send_byte(8'h81, 1'b1, 1'b1, 1'b0);
        send_stop();
        tick(4);
        chk("rs_start", 32'(n_start - s0), 32'd2);
        chk("rs_valid", 32'(n_valid - v0), 32'd1);
        chk("rs_stop",  32'(n_stop - p0), 32'd1);
        chk("rs_byte",  32'(byte_out), 32'h0000_0081);
        scl_in = 1'b0;
        tick(Q);
        send_byte(8'h77, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk("idle_no_valid", 32'(n_valid - v0), 32'd1);
        chk("idle_byte", 32'(byte_out), 32'h0000_0081);
        chk("rs_evq", 32'(evq.size()), 32'd0);

        // SCL glitches during 0x5A
        snap();
        send_start();
        send_byte(8'h5A, 1'b1, 1'b1, 1'b1);
        send_stop();
        tick(4);
        chk("glitch_byte",  32'(byte_out), 32'h0000_005A);
        chk("glitch_valid", 32'(n_valid - v0), 32'd1);
        chk("glitch_evq", 32'(evq.size()), 32'd0);

        // Reset while driving ACK, then a byte without START
        snap();
        send_start();
        ack_in = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) evq.push_back('{K_VALID, 8'hC3});
            send_bit(1'(8'hC3 >> i), 1'b0, 1'b0);
        end
        sda_m = 1'b1;
        tick(Q);
        scl_in = 1'b1;
        tick(6);
        chk("ack_driven", 32'(sda_oe_out), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_release", 32'(sda_oe_out), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_byte", 32'(byte_out), 32'd0);
        scl_in = 1'b0;
        tick(Q);
        send_byte(8'h99, 1'b1, 1'b0, 1'b0);
        tick(10);
        chk("rst_valid_cnt", 32'(n_valid - v0), 32'd1);
        chk("rst_start_cnt", 32'(n_start - s0), 32'd1);
        chk("rst_evq", 32'(evq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
